// File: rtl/i2s_tx_stream.sv
// I2S stereo transmitter: sample-pair FIFO, MCLK/SCLK/LRCK generation, MSB-first serialiser.
// Optional build macro I2S_TX_VOLUME_EN adds a 4-bit attenuation input (vol) applied at frame load.
module i2s_tx_stream #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int SCLK_DIV   = 16,
  parameter int MCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
`ifdef I2S_TX_VOLUME_EN
  input  logic [3:0]                    vol,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          mclk,
  output logic                          sclk,
  output logic                          lrck,
  output logic                          sdin
);

  localparam int MW = $clog2(MCLK_DIV);
  localparam int SW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * SLOT_W;

  localparam logic [MW-1:0] MCLK_LAST  = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] MCLK_HALF  = MW'(MCLK_DIV / 2);
  localparam logic [SW-1:0] SCLK_LAST  = SW'(SCLK_DIV - 1);
  localparam logic [SW-1:0] SCLK_HALF  = SW'(SCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST   = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] BIT_SLOT   = BW'(SLOT_W);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic [MW-1:0] mclk_cnt, mclk_cnt_nxt;
  logic [SW-1:0] sclk_cnt, sclk_cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [FW-1:0] shifter;
  logic          boundary, load;

  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                fifo_empty, push, pop;

  logic signed [SAMPLE_W-1:0] head_l, head_r;
  logic [SLOT_W-1:0]          slot_l, slot_r;

  assign mclk_cnt_nxt = (mclk_cnt == MCLK_LAST) ? '0 : mclk_cnt + 1'b1;
  assign sclk_cnt_nxt = (sclk_cnt == SCLK_LAST) ? '0 : sclk_cnt + 1'b1;
  assign bit_cnt_nxt  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

  // A bit period ends on the SCLK falling edge; the frame reloads when entering bit 1.
  assign boundary = (sclk_cnt == SCLK_LAST);
  assign load     = boundary && (bit_cnt == '0);

  assign s_ready    = (fifo_level != LEVEL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign push       = s_valid && s_ready;
  assign pop        = load && !fifo_empty;

  assign sdin = shifter[FW-1];

  always_comb begin
    head_l = mem_l[rd_ptr];
    head_r = mem_r[rd_ptr];
`ifdef I2S_TX_VOLUME_EN
    head_l = head_l >>> vol;
    head_r = head_r >>> vol;
`endif
    // MSB-align in the slot; any sign bits from widening are shifted out.
    slot_l = SLOT_W'(head_l) << (SLOT_W - SAMPLE_W);
    slot_r = SLOT_W'(head_r) << (SLOT_W - SAMPLE_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_cnt <= '0;
      sclk_cnt <= '0;
      bit_cnt  <= '0;
      mclk     <= 1'b0;
      sclk     <= 1'b0;
      lrck     <= 1'b0;
      shifter  <= '0;
      underrun <= 1'b0;
    end else begin
      mclk_cnt <= mclk_cnt_nxt;
      sclk_cnt <= sclk_cnt_nxt;
      mclk     <= (mclk_cnt_nxt >= MCLK_HALF);
      sclk     <= (sclk_cnt_nxt >= SCLK_HALF);
      underrun <= load && fifo_empty;
      if (boundary) begin
        bit_cnt <= bit_cnt_nxt;
        lrck    <= (bit_cnt_nxt >= BIT_SLOT);
        if (bit_cnt == '0) begin
          shifter <= pop ? {slot_l, slot_r} : '0;
        end else begin
          shifter <= {shifter[FW-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: default instance checked every clock against a frame-level model,
// plus two narrow-sample instances (12-bit in 16- and 24-bit slots) checked by frame capture.
module tb_i2s_tx_stream;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 16;
  localparam int SCLK_DIV   = 16;
  localparam int MCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CLK  = 2 * SLOT_W * SCLK_DIV;
  localparam int WAIT_MAX   = 3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                s_valid, s_ready;
  logic [SAMPLE_W-1:0] s_left, s_right;
  logic [2:0]          fifo_level;
  logic                underrun, mclk, sclk, lrck, sdin;
  logic [3:0]          vol;

  logic        w16_valid, w16_ready, w16_under, w16_mclk, w16_sclk, w16_lrck, w16_sdin;
  logic        w24_valid, w24_ready, w24_under, w24_mclk, w24_sclk, w24_lrck, w24_sdin;
  logic [1:0]  w16_level, w24_level;
  logic [11:0] w_left, w_right;

  i2s_tx_stream #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .SCLK_DIV(SCLK_DIV),
                  .MCLK_DIV(MCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right),
`ifdef I2S_TX_VOLUME_EN
    .vol(vol),
`endif
    .fifo_level(fifo_level), .underrun(underrun),
    .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdin(sdin)
  );

  i2s_tx_stream #(.SAMPLE_W(12), .SLOT_W(16), .SCLK_DIV(4), .MCLK_DIV(2), .FIFO_DEPTH(2)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .s_valid(w16_valid), .s_ready(w16_ready),
    .s_left(w_left), .s_right(w_right),
`ifdef I2S_TX_VOLUME_EN
    .vol(vol),
`endif
    .fifo_level(w16_level), .underrun(w16_under),
    .mclk(w16_mclk), .sclk(w16_sclk), .lrck(w16_lrck), .sdin(w16_sdin)
  );

  i2s_tx_stream #(.SAMPLE_W(12), .SLOT_W(24), .SCLK_DIV(4), .MCLK_DIV(2), .FIFO_DEPTH(2)) dut_w24 (
    .clk(clk), .rst_n(rst_n), .s_valid(w24_valid), .s_ready(w24_ready),
    .s_left(w_left), .s_right(w_right),
`ifdef I2S_TX_VOLUME_EN
    .vol(vol),
`endif
    .fifo_level(w24_level), .underrun(w24_under),
    .mclk(w24_mclk), .sclk(w24_sclk), .lrck(w24_lrck), .sdin(w24_sdin)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard / reference model state
  logic [2*SAMPLE_W-1:0] exp_q[$];
  logic [2*SLOT_W-1:0]   cur_frame;
  int n;
  int pend16, pend24;

  // Floor division by 2**v, i.e. an arithmetic right shift expressed as plain arithmetic.
  function automatic int scale(input logic [15:0] s, input int v);
    int x, d, q;
    x = int'($signed(s));
    d = 1 << v;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] make_frame(input logic [31:0] pair, input int v);
    logic [15:0] l, r;
    l = 16'(scale(pair[31:16], v));
    r = 16'(scale(pair[15:0], v));
    return {l, r};
  endfunction

  function automatic logic [47:0] exp_lr(input int slot);
    logic [47:0] v;
    v = '0;
    for (int k = 0; k < 2 * slot; k++) v[2*slot-1-k] = (((k + 1) % (2 * slot)) >= slot);
    return v;
  endfunction

  task automatic step_w(input string tag, input int slot, input logic v, input logic rdy,
                        input logic [1:0] lvl, input logic und, input logic mc, input logic sc,
                        input int pend_i, output int pend_o);
    logic ld, acc;
    ld  = (n % 4 == 0) && ((n / 4) % (2 * slot) == 1);
    acc = v && (pend_i < 2);
    pend_o = pend_i;
    check_eq({tag, "_under"}, und, ld && (pend_i == 0));
    if (ld && pend_o > 0) pend_o--;
    if (acc) pend_o++;
    check_eq({tag, "_level"}, lvl, pend_o);
    check_eq({tag, "_ready"}, rdy, pend_o != 2);
    check_eq({tag, "_mclk"}, mc, (n % 2) >= 1);
    check_eq({tag, "_sclk"}, sc, (n % 4) >= 2);
  endtask

  // per-clock monitor: n counts clock edges since reset release
  initial begin
    int bit_i, cur_vol, p16, p24;
    logic ld, acc, exp_under, exp_sdin;
    logic [31:0] pair;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        n = 0;
        exp_q.delete();
        cur_frame = '0;
        pend16 = 0;
        pend24 = 0;
        check_eq("rst_mclk", mclk, 0);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_lrck", lrck, 0);
        check_eq("rst_sdin", sdin, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_ready", s_ready, 1);
      end else begin
        n++;
`ifdef I2S_TX_VOLUME_EN
        cur_vol = int'(vol);
`else
        cur_vol = 0;
`endif
        bit_i = (n / SCLK_DIV) % (2 * SLOT_W);
        ld  = (n % SCLK_DIV == 0) && (bit_i == 1);
        acc = s_valid && (exp_q.size() < FIFO_DEPTH);
        exp_under = 1'b0;
        if (ld) begin
          if (exp_q.size() > 0) begin
            pair = exp_q.pop_front();
            cur_frame = make_frame(pair, cur_vol);
          end else begin
            cur_frame = '0;
            exp_under = 1'b1;
          end
        end
        if (acc) exp_q.push_back({s_left, s_right});
        exp_sdin = (bit_i == 0) ? cur_frame[0] : cur_frame[2*SLOT_W-bit_i];
        check_eq("mclk", mclk, (n % MCLK_DIV) >= MCLK_DIV / 2);
        check_eq("sclk", sclk, (n % SCLK_DIV) >= SCLK_DIV / 2);
        check_eq("lrck", lrck, bit_i >= SLOT_W);
        check_eq("sdin", sdin, exp_sdin);
        check_eq("underrun", underrun, exp_under);
        check_eq("level", fifo_level, exp_q.size());
        check_eq("ready", s_ready, exp_q.size() != FIFO_DEPTH);
        step_w("w16", 16, w16_valid, w16_ready, w16_level, w16_under, w16_mclk, w16_sclk, pend16, p16);
        step_w("w24", 24, w24_valid, w24_ready, w24_level, w24_under, w24_mclk, w24_sclk, pend24, p24);
        pend16 = p16;
        pend24 = p24;
      end
    end
  end

  // driver tasks; all start and end at a falling clock edge
  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    logic seen;
    int waited;
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < WAIT_MAX) begin
      seen = s_ready;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    s_valid = 1'b0;
    check_eq("push_accept", seen, 1);
  endtask

  // returns at posedge+2 of the first edge with n % modv == rem
  task automatic wait_sync(input int modv, input int rem);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX && !ok; i++) begin
      @(posedge clk);
      #2;
      if (n % modv == rem) ok = 1'b1;
    end
    check_eq("sync", ok, 1);
  endtask

  // sel 0: main, 1: w16, 2: w24. Samples each bit mid-period, from period 1 to next period 0.
  task automatic capture(input int sel, output logic [47:0] data, output logic [47:0] lr);
    int div, slot;
    div  = (sel == 0) ? SCLK_DIV : 4;
    slot = (sel == 2) ? 24 : 16;
    data = '0;
    lr   = '0;
    wait_sync(2 * slot * div, div);
    repeat (div / 2) @(posedge clk);
    for (int k = 0; k < 2 * slot; k++) begin
      if (k > 0) repeat (div) @(posedge clk);
      #2;
      case (sel)
        0:       begin data[2*slot-1-k] = sdin;     lr[2*slot-1-k] = lrck;     end
        1:       begin data[2*slot-1-k] = w16_sdin; lr[2*slot-1-k] = w16_lrck; end
        default: begin data[2*slot-1-k] = w24_sdin; lr[2*slot-1-k] = w24_lrck; end
      endcase
    end
  endtask

  initial begin
    logic [47:0] data, lr;
    s_valid = 1'b0; s_left = '0; s_right = '0;
    w16_valid = 1'b0; w24_valid = 1'b0; w_left = '0; w_right = '0;
    vol = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // first load finds nothing queued
    wait_sync(FRAME_CLK, SCLK_DIV);
    check_eq("first_underrun", underrun, 1);
    @(posedge clk);
    #2;
    check_eq("underrun_width", underrun, 0);
    @(negedge clk);

    push_pair(16'hA5F0, 16'h0F0F);
    capture(0, data, lr);
    check_eq("ser_frame", data, 48'h0000_A5F0_0F0F);
    check_eq("ser_lrck", lr, exp_lr(16));

    @(negedge clk);
    w_left = 12'h801; w_right = 12'h7FE; w16_valid = 1'b1;
    @(negedge clk);
    w16_valid = 1'b0;
    capture(1, data, lr);
    check_eq("w16_frame", data, 48'h0000_8010_7FE0);
    check_eq("w16_lrck", lr, exp_lr(16));

    @(negedge clk);
    w24_valid = 1'b1;
    @(negedge clk);
    w24_valid = 1'b0;
    capture(2, data, lr);
    check_eq("w24_frame", data, 48'h801000_7FE000);
    check_eq("w24_lrck", lr, exp_lr(24));

    // backpressure: four fill the FIFO, the fifth waits for the next load
    wait_sync(FRAME_CLK, SCLK_DIV);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(16'($urandom), 16'($urandom));
    check_eq("bp_level_full", fifo_level, 4);
    check_eq("bp_ready_low", s_ready, 0);
    push_pair(16'($urandom), 16'($urandom));
    check_eq("bp_accept_phase", n % FRAME_CLK, SCLK_DIV + 1);
    check_eq("bp_level_refill", fifo_level, 4);

    // random traffic with random gaps
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
`ifdef I2S_TX_VOLUME_EN
      vol = 4'($urandom_range(0, 15));
`endif
      push_pair(16'($urandom), 16'($urandom));
    end

    // asynchronous reset in the middle of a frame
    push_pair(16'($urandom), 16'($urandom));
    wait_sync(FRAME_CLK, 200);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_sclk", sclk, 0);
    check_eq("async_rst_mclk", mclk, 0);
    check_eq("async_rst_lrck", lrck, 0);
    check_eq("async_rst_sdin", sdin, 0);
    check_eq("async_rst_level", fifo_level, 0);
    check_eq("async_rst_ready", s_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

`ifdef I2S_TX_VOLUME_EN
    vol = 4'd2;
    push_pair(16'h8000, 16'h4000);
    capture(0, data, lr);
    check_eq("vol_frame", data, 48'h0000_E000_1000);
    // vol changes mid-frame must only affect the following frame
    @(negedge clk);
    vol = 4'd3;
    push_pair(16'($urandom), 16'($urandom));
    wait_sync(FRAME_CLK, SCLK_DIV);
    @(negedge clk);
    repeat (100) @(negedge clk);
    vol = 4'd11;
    push_pair(16'($urandom), 16'($urandom));
`endif

    repeat (6 * FRAME_CLK) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
